// File: rtl/ones_counter_feeder_if.sv
// Bundle of the producer-side push handshake and the counter-side job
// signals of the ones-counter feeder.
//
// Handshake: a push completes on a rising edge of CLK where PushValid and
// PushReady are both 1. PushReady depends only on registered occupancy, never
// on PushValid. The producer keeps PushData stable while PushValid is 1.
// On the counter side Start is a one-cycle strobe qualifying DataIn, and Done
// is a level sampled every edge.
interface ones_counter_feeder_if #(
  parameter int bitInput = 8,
  parameter int ptrWidth = 2
);
  logic                PushValid;
  logic [bitInput-1:0] PushData;
  logic                PushReady;
  logic                Start;
  logic [bitInput-1:0] DataIn;
  logic                Done;
  logic                Busy;
  logic [ptrWidth:0]   Level;
  logic                Error;

  // Environment side: producer plus counter.
  modport master (
    output PushValid, PushData, Done,
    input  PushReady, Start, DataIn, Busy, Level, Error
  );

  // Feeder side.
  modport slave (
    input  PushValid, PushData, Done,
    output PushReady, Start, DataIn, Busy, Level, Error
  );
endinterface

// File: rtl/ones_counter_feeder.sv
// Word sequencer for the ones-counter: a small circular FIFO feeding one word
// at a time to the counter, with a start strobe, done wait and a watchdog
// that aborts a hung job and latches a sticky error.
module ones_counter_feeder #(
  parameter int bitInput = 8,
  parameter int depth    = 4,
  parameter int ptrWidth = 2,
  parameter int timeout  = 20
) (
  input  logic                  CLK,
  input  logic                  Reset,
  ones_counter_feeder_if.slave  bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Timer only needs to reach timeout-1.
  localparam int TW = (timeout > 2) ? $clog2(timeout) : 1;
  localparam logic [ptrWidth:0] FULL_LVL   = (ptrWidth+1)'(depth);
  localparam logic [TW-1:0]     TIMER_LAST = TW'(timeout - 1);

  state_e                state_q, state_d;
  logic [ptrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ptrWidth:0]     count_q, count_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  start_q, start_d;
  logic [bitInput-1:0]   data_in_q, data_in_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic [bitInput-1:0]   mem_q [depth];

  logic push_fire;
  logic pop_en;
  logic done_seen;
  logic fifo_full;
  logic fifo_empty;

  // Handshake and status decodes from registered state only.
  always_comb begin
    fifo_full  = (count_q == FULL_LVL);
    fifo_empty = (count_q == '0);
    push_fire  = bus.PushValid && !fifo_full;
    // Done counts only once the timer has moved, masking a stale level.
    done_seen  = bus.Done && (timer_q != '0);
  end

  // State register plus all datapath/status flops.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      start_q   <= 1'b0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      start_q   <= start_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= bus.PushData;
    end
  end

  // Next-state logic of the job sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_seen || (timer_q == TIMER_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: pop/start in IDLE, timer clear in LOAD, watchdog in WAIT.
  always_comb begin
    pop_en    = 1'b0;
    start_d   = 1'b0;
    data_in_d = data_in_q;
    timer_d   = timer_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_en    = 1'b1;
          start_d   = 1'b1;
          data_in_d = mem_q[rd_ptr_q];
        end
      end
      ST_LOAD: begin
        timer_d = '0;
      end
      ST_WAIT: begin
        if (done_seen) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          // Abort: the word is dropped and the flag stays set until reset.
          timer_d = '0;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_fire, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign bus.PushReady = !fifo_full;
  assign bus.Start     = start_q;
  assign bus.DataIn    = data_in_q;
  assign bus.Busy      = busy_q;
  assign bus.Level     = count_q;
  assign bus.Error     = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ones_counter_feeder.sv
// Directed bench for ones_counter_feeder: a scoreboard queue holds words in
// the order they should reach DataIn; a monitor pops it on every Start.
module tb_ones_counter_feeder;

  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int TMO   = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ones_counter_feeder_if #(.bitInput(BW), .ptrWidth(PW)) bus ();
  logic [1:0] dbg_state;

  ones_counter_feeder #(
    .bitInput(BW), .depth(DEPTH), .ptrWidth(PW), .timeout(TMO)
  ) dut (
    .CLK       (clk),
    .Reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept: whether this push is expected to enter the FIFO.
  task automatic push_word(input logic [BW-1:0] w, input bit accept);
    bus.PushValid = 1'b1;
    bus.PushData  = w;
    if (accept) exp_q.push_back(w);
    tick();
    bus.PushValid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!bus.Start && n < 40) begin
      tick();
      n++;
    end
    check(name, bus.Start, 1);
  endtask

  // Called just after the pop edge; completes with Done at the first eligible edge.
  task automatic run_job(input string name);
    tick();
    check({name, "_start_fall"}, bus.Start, 0);
    check({name, "_busy_mid"}, bus.Busy, 1);
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    check({name, "_busy_end"}, bus.Busy, 0);
  endtask

  // ---------------- monitor ----------------
  logic prev_start = 1'b0;
  logic [BW-1:0] exp_w;
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (bus.Start) begin
        check("start_one_cycle", prev_start, 0);
        if (exp_q.size() == 0) begin
          check("start_without_word", bus.Start, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("data_in", bus.DataIn, exp_w);
          check("level_bound", bus.Level <= DEPTH, 1);
        end
      end
      prev_start = bus.Start;
    end
  end

  // Global bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.PushValid = 1'b0;
    bus.PushData  = '0;
    bus.Done      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_start", bus.Start, 0);
    check("rst_data_in", bus.DataIn, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_error", bus.Error, 0);
    check("rst_level", bus.Level, 0);
    check("rst_push_ready", bus.PushReady, 1);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single word A5
    push_word(8'hA5, 1);
    check("single_level_after_push", bus.Level, 1);
    tick();
    check("single_start", bus.Start, 1);
    check("single_level_after_pop", bus.Level, 0);
    run_job("single");
    check("single_error", bus.Error, 0);
    repeat (2) tick();

    // Fill/full: 01 issued, 02..05 fill, 06 dropped
    push_word(8'h01, 1);
    push_word(8'h02, 1);
    push_word(8'h03, 1);
    push_word(8'h04, 1);
    push_word(8'h05, 1);
    check("full_level", bus.Level, 4);
    check("full_push_ready", bus.PushReady, 0);
    check("full_busy", bus.Busy, 1);
    push_word(8'h06, 0);
    check("full_level_after_drop", bus.Level, 4);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    check("full_first_done", bus.Busy, 0);
    for (int i = 0; i < 4; i++) begin
      wait_start("full_wait_start");
      run_job("full");
    end
    repeat (8) tick();
    check("full_drained_level", bus.Level, 0);

    // Wrap-around: 10..19 in pairs
    for (int k = 0; k < 5; k++) begin
      push_word(8'h10 + 8'(2 * k), 1);
      push_word(8'h11 + 8'(2 * k), 1);
      check("wrap_level", bus.Level, 1);
      wait_start("wrap_wait_start");
      run_job("wrap");
      wait_start("wrap_wait_start");
      run_job("wrap");
    end
    repeat (2) tick();

    // Stale Done held high
    bus.Done = 1'b1;
    tick();
    push_word(8'h77, 1);
    push_word(8'h88, 1);
    for (int i = 0; i < 2; i++) begin
      wait_start("stale_wait_start");
      tick();
      tick();
      check("stale_busy_timer0", bus.Busy, 1);
      tick();
      check("stale_busy_done", bus.Busy, 0);
    end
    bus.Done = 1'b0;
    repeat (2) tick();

    // Watchdog
    push_word(8'h3C, 1);
    wait_start("wd_wait_start");
    repeat (TMO) tick();
    check("wd_busy_before", bus.Busy, 1);
    check("wd_error_before", bus.Error, 0);
    tick();
    check("wd_error_after", bus.Error, 1);
    check("wd_busy_after", bus.Busy, 0);
    push_word(8'hC3, 1);
    wait_start("wd_next_start");
    run_job("wd_next");
    check("wd_error_sticky", bus.Error, 1);

    // Reset mid-operation in WAIT with Level=3
    push_word(8'hD0, 1);
    push_word(8'hD1, 1);
    push_word(8'hD2, 1);
    push_word(8'hD3, 1);
    check("mid_level", bus.Level, 3);
    check("mid_state_wait", dbg_state, 2);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_start", bus.Start, 0);
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_level", bus.Level, 0);
    check("mid_rst_push_ready", bus.PushReady, 1);
    check("mid_rst_data_in", bus.DataIn, 0);
    check("mid_rst_error", bus.Error, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("post_rst_level", bus.Level, 0);
    check("post_rst_busy", bus.Busy, 0);
    push_word(8'h5A, 1);
    wait_start("post_rst_start");
    run_job("post_rst");

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
